// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encodings, defaults and widths for bus_arbiter
package bus_arbiter_pkg;

    // Arbiter phases: waiting to pick, an owner holds the bus, all-off gap
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_HOLD   = 8;
    localparam int DEF_TURNAROUND = 1;

    // Owner index width covers up to 8 requesters
    localparam int OWNER_W = 3;

    // Width of the hold counter; MAX_HOLD tops out at 255
    localparam int HOLD_W = 8;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin selector searching upward from last_ptr+1
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] last_ptr,
    output logic [OWNER_W-1:0] pick,
    output logic               any_req
);

    // Walk the requesters starting just after the previous winner; first hit wins
    always_comb begin
        int idx;
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_ptr) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = OWNER_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin tsg_32 bus ownership sequencer; option macro BUS_ARB_PRIORITY_EN
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_HOLD   = DEF_MAX_HOLD,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] owner,
    output logic               bus_busy,
    output logic               timeout
);

    arb_state_t         state, state_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_d;
    logic [1:0]         turn_cnt, turn_d;
    logic [OWNER_W-1:0] last_ptr, last_d, owner_d, pick, win;
    logic [NUM_REQ-1:0] grant_d;
    logic               timeout_d;
    logic               any_req;
    logic               owner_req;
    logic               hold_last;
    logic               turn_last;
    logic               prio_win;
    logic               hold_exempt;
    logic               revoke;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .pick     (pick),
        .any_req  (any_req)
    );

    // grant is one-hot on the owner while in GRANT, so this is req[owner] without an out-of-range index
    assign owner_req = |(req & grant);
    assign hold_last = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign turn_last = (turn_cnt == 2'(TURNAROUND - 1));
    assign revoke    = owner_req && hold_last && !hold_exempt;

`ifdef BUS_ARB_PRIORITY_EN
    logic prio_q;

    // Remember whether the current grant came from the urgent master so it is never timed out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (state == ST_IDLE && any_req) begin
            prio_q <= req[0];
        end
    end

    assign prio_win    = req[0];
    assign hold_exempt = prio_q;
`else
    assign prio_win    = 1'b0;
    assign hold_exempt = 1'b0;
`endif

    assign win = prio_win ? '0 : pick;

    // State and registered outputs; reset also drops any live grant on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            last_ptr <= OWNER_W'(NUM_REQ - 1);
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            owner    <= owner_d;
            bus_busy <= |grant_d;
            timeout  <= timeout_d;
            hold_cnt <= hold_d;
            turn_cnt <= turn_d;
            last_ptr <= last_d;
        end
    end

    // Next phase: pick when anyone asks, release on drop or hold limit, leave the gap after TURNAROUND cycles
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (any_req) state_d = ST_GRANT;
            ST_GRANT: if (!owner_req || revoke) state_d = ST_TURN;
            ST_TURN:  if (turn_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters
    always_comb begin
        grant_d   = grant;
        owner_d   = owner;
        last_d    = last_ptr;
        hold_d    = hold_cnt;
        turn_d    = turn_cnt;
        timeout_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = NUM_REQ'(1) << win;
                    owner_d = win;
                    hold_d  = '0;
                    if (!prio_win) last_d = pick;
                end
            end
            ST_GRANT: begin
                if (!owner_req || revoke) begin
                    grant_d   = '0;
                    turn_d    = '0;
                    timeout_d = revoke;
                end else if (!hold_last) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (!turn_last) turn_d = turn_cnt + 1'b1;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

endmodule
